comparator_sweeper: RTL
=======================

Name: comparator_sweeper

Overview:
- Self-checking stimulus engine that drives the opposite end of the WIDTH-bit magnitude-comparator interface.
- Generates operands a and b, and samples the comparator's result flags x, y and z.
- Exhaustively sweeps all 2^(2*WIDTH) operand pairs, checks each result against an internal expected value, counts mismatches and records the first failing pair.
- Used for on-chip self-test of comparator instances and as a reusable verification driver.

Parameters:
- WIDTH, 4, operand width; sweep covers 2^(2*WIDTH) vectors.
- SETTLE, 1, extra wait cycles between applying a vector and sampling results (min 0); vector period P = SETTLE+1.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- a_out  out  WIDTH  operand a to comparator.
- b_out  out  WIDTH  operand b to comparator.
- x_in  in  1  comparator flag, defined as a>b.
- y_in  in  1  comparator flag, defined as a==b.
- z_in  in  1  comparator flag, defined as a<b.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until next start or reset.
- pass  out  1  done && err_count==0.
- err_count  out  2*WIDTH+1  number of failing vectors.
- fail_a  out  WIDTH  a of first failing vector (0 if none).
- fail_b  out  WIDTH  b of first failing vector (0 if none).

Behaviour:
- Reset: all outputs 0, state IDLE. Asynchronous assert, synchronous release. Reset mid-sweep aborts immediately; there is no resume.
- FSM states IDLE, APPLY, WAIT, DONE.
  - IDLE/DONE + start=1: clear err_count, fail_a and fail_b; load vector index 0; busy=1; done=0; go to APPLY.
- Vector index i (2*WIDTH bits): a_out = i[2W-1:W], b_out = i[W-1:0]. a is outer and b inner: (0,0), (0,1), ..., (0,15), (1,0), ...
- Timing:
  - Vector k is applied at edge k*P after the start edge (edge 0).
  - x/y/z are sampled at edge (k+1)*P.
  - The next vector is applied on that same edge.
  - WAIT counts SETTLE cycles; with SETTLE=0 the block goes APPLY->APPLY.
- Check at sample edge:
  - Expected value is x=(a>b), y=(a==b), z=(a<b), unsigned.
  - Any flag mismatch counts as one error per vector, regardless of how many flags differ. This implicitly includes one-hot violations.
  - On the first error, latch fail_a/fail_b.
- Completion:
  - The sample edge of the last vector (index 2^(2W)-1) updates err_count, sets done=1 and busy=0, and moves to DONE.
  - a_out/b_out return to 0 in DONE/IDLE.
- err_count is wide enough for all vectors to fail and never wraps.
- start while busy is ignored.
- start in DONE restarts a full sweep and clears the results on the same edge.
- pass is combinational from done and err_count.

Optional Feature:
- Macro: COMPARATOR_SWEEPER_STOP_ON_FAIL_EN.
- Defined: the first failing sample edge ends the sweep on that edge (done=1, busy=0, err_count=1, fail_a/fail_b latched).
- Undefined: the sweep always covers every vector, and err_count totals all failures.

Test Plan:
- Correct comparator model, WIDTH=4, SETTLE=1, start pulse -> busy for 512 cycles, done=1 at edge 512, err_count=0, pass=1, fail_a=fail_b=0.
- Faulty model forcing y=0 when a==b -> err_count=16, pass=0, fail_a=0, fail_b=0.
- Model with x stuck at 1 -> err_count=136 (all a<=b vectors), fail_a=0, fail_b=0.
- rst_n low during vector 100 -> all outputs 0 asynchronously. A later start sweeps from (0,0) and completes with err_count=0.
- SETTLE=3 with a model that is correct but has 3-cycle output latency -> done at edge 1024, err_count=0. Same model with SETTLE=0 -> err_count>0.
- start asserted while busy -> no effect on vector order or timing. start held in DONE -> results cleared and a new 512-cycle sweep begins.
- With COMPARATOR_SWEEPER_STOP_ON_FAIL_EN and the y-fault model -> done at edge 2, err_count=1, fail_a=0, fail_b=0.

Source files
------------

// File: rtl/comparator_sweeper.sv
// Exhaustive stimulus/check engine for a WIDTH-bit magnitude comparator (x=a>b, y=a==b, z=a<b).
// Optional: define COMPARATOR_SWEEPER_STOP_ON_FAIL_EN to end the sweep on the first failing vector.
module comparator_sweeper #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               x_in,
    input  logic               y_in,
    input  logic               z_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    // state | meaning
    // IDLE  | waiting for start, operands held at 0
    // APPLY | first cycle of a vector period, settle timer loaded
    // WAIT  | settle timer running; terminal count is the sample edge
    // DONE  | sweep finished, results held until start or reset

    localparam int IW        = 2 * WIDTH;
    localparam int SETTLE_M1 = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam int CW        = (SETTLE_M1 > 0) ? $clog2(SETTLE_M1 + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_WAIT, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   settle_cnt;
    logic            start_ok;
    logic            sample;
    logic            last_vec;
    logic            mismatch;
    logic            finish;
    logic [2:0]      flags_exp;

    assign a_out     = idx[IW-1:WIDTH];
    assign b_out     = idx[WIDTH-1:0];
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_vec  = &idx;
    assign flags_exp = {a_out > b_out, a_out == b_out, a_out < b_out};
    assign mismatch  = {x_in, y_in, z_in} != flags_exp;

    // With SETTLE=0 every APPLY cycle is already a sample edge.
    always_comb begin
        sample = 1'b0;
        if (state == S_APPLY)
            sample = (SETTLE == 0);
        else if (state == S_WAIT)
            sample = (settle_cnt == '0);
    end

`ifdef COMPARATOR_SWEEPER_STOP_ON_FAIL_EN
    assign finish = sample && (last_vec || mismatch);
`else
    assign finish = sample && last_vec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start)
                    state_nxt = S_APPLY;
            end
            S_APPLY, S_WAIT: begin
                if (sample)
                    state_nxt = finish ? S_DONE : S_APPLY;
                else
                    state_nxt = S_WAIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_APPLY) || (state == S_WAIT);
        done = (state == S_DONE);
        pass = done && (err_count == '0);
    end

    // idx wraps to 0 after the last vector, so operands park at 0 in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else if (start_ok) begin
            idx        <= '0;
            settle_cnt <= CW'(SETTLE_M1);
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            if (state == S_APPLY)
                settle_cnt <= CW'(SETTLE_M1);
            else if ((state == S_WAIT) && !sample)
                settle_cnt <= settle_cnt - 1'b1;

            if (sample) begin
                if (mismatch) begin
                    err_count <= err_count + 1'b1;
                    if (err_count == '0) begin
                        fail_a <= a_out;
                        fail_b <= b_out;
                    end
                end
                idx <= finish ? '0 : idx + 1'b1;
            end
        end
    end

endmodule
